// File: rtl/hoeraa_adder_pkg.sv
// Shared defaults and the lower-part fill rule for the HOERAA approximate adder.
package hoeraa_adder_pkg;

  localparam int unsigned HOERAA_N_DEFAULT = 16;
  localparam int unsigned HOERAA_K_DEFAULT = 10;

  // Value replicated across S[K-2:0]: zeros only when the top pair generates
  // a carry and the pair below it cannot compensate.
  function automatic logic lower_fill(input logic g, input logic t);
    return ~g | t;
  endfunction

endpackage

// File: rtl/hoeraa_lower.sv
// Carry-free approximate lower part: K sum bits plus the carry handed upward.
module hoeraa_lower
  import hoeraa_adder_pkg::*;
#(
  parameter int unsigned K = HOERAA_K_DEFAULT
) (
  input  logic [K-1:0] X,
  input  logic [K-1:0] Y,
  output logic [K-1:0] S,
  output logic         cout
);

  logic g;
  logic t;

  assign g    = X[K-1] & Y[K-1];
  assign t    = X[K-2] & Y[K-2];
  assign cout = g;

  always_comb begin
    S        = {K{lower_fill(g, t)}};
    S[K-1]   = (X[K-1] ^ Y[K-1]) | t;
  end

endmodule

// File: rtl/hoeraa_adder.sv
// Registered approximate adder: exact (N-K)-bit upper adder fed by an approximate K-bit lower part.
module hoeraa_adder
  import hoeraa_adder_pkg::*;
#(
  parameter int unsigned N = HOERAA_N_DEFAULT,
  parameter int unsigned K = HOERAA_K_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  output logic [N-1:0] S,
  output logic         Co
);

  localparam int unsigned UW = N - K;

  if (K < 2 || K > N - 1) begin : g_bad_k
    $error("hoeraa_adder: K must satisfy 2 <= K <= N-1");
  end

  logic [K-1:0]  lower_s_p0;
  logic          lower_c_p0;
  logic [UW:0]   upper_p0;

  hoeraa_lower #(.K(K)) u_lower (
    .X    (X[K-1:0]),
    .Y    (Y[K-1:0]),
    .S    (lower_s_p0),
    .cout (lower_c_p0)
  );

  assign upper_p0 = {1'b0, X[N-1:K]} + {1'b0, Y[N-1:K]} + {{UW{1'b0}}, lower_c_p0};

  // p0 -> p1: result register; data holds while in_valid is low
  logic [N-1:0] sum_p1;
  logic         co_p1;
  logic         vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      co_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1 <= {upper_p0[UW-1:0], lower_s_p0};
        co_p1  <= upper_p0[UW];
      end
    end
  end

  assign S         = sum_p1;
  assign Co        = co_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_hoeraa_adder.sv
// Directed and randomised bench for hoeraa_adder (N=16, K=10).
module tb_hoeraa_adder;

  localparam int N = 16;
  localparam int K = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  X = '0;
  logic [N-1:0]  Y = '0;
  logic          out_valid;
  logic [N-1:0]  S;
  logic          Co;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N-1:0] exp_s  = '0;
  logic         exp_co = 1'b0;

  hoeraa_adder #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .S         (S),
    .Co        (Co)
  );

  always #5 clk = ~clk;

  // Reference model built from the arithmetic rules with plain integers.
  function automatic logic [N:0] ref_add(input int unsigned x, input int unsigned y);
    int unsigned g, t, upper, low, low_top, res;
    g       = ((x >> (K-1)) & 1) & ((y >> (K-1)) & 1);
    t       = ((x >> (K-2)) & 1) & ((y >> (K-2)) & 1);
    low_top = (((x >> (K-1)) ^ (y >> (K-1))) & 1) | t;
    low     = (g == 1 && t == 0) ? 0 : ((1 << (K-1)) - 1);
    low     = low + (low_top << (K-1));
    upper   = (x >> K) + (y >> K) + g;
    res     = (upper << K) + low;
    return res[N:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Apply one operand pair (or an idle cycle) and check the registered outputs.
  task automatic step(input logic v, input logic [N-1:0] x, input logic [N-1:0] y,
                      input string tag);
    logic [N:0] r;
    @(negedge clk);
    in_valid = v;
    X = x;
    Y = y;
    if (v) begin
      r      = ref_add(x, y);
      exp_s  = r[N-1:0];
      exp_co = r[N];
    end
    @(posedge clk);
    #1;
    check({tag, ".S"},  {16'h0, S},  {16'h0, exp_s});
    check({tag, ".Co"}, {31'h0, Co}, {31'h0, exp_co});
    check({tag, ".vld"}, {31'h0, out_valid}, {31'h0, v});
  endtask

  initial begin
    real         err_sum;
    int unsigned xr, yr, exact;
    logic [N:0]  r;

    #2;
    check("reset.S",   {16'h0, S},  32'h0);
    check("reset.Co",  {31'h0, Co}, 32'h0);
    check("reset.vld", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived results
    step(1'b1, 16'h0001, 16'h0001, "d01");
    check("d01.const", {16'h0, S}, 32'h01FF);
    step(1'b1, 16'h00FF, 16'h00FF, "d02");
    check("d02.const", {16'h0, S}, 32'h01FF);
    step(1'b1, 16'h8001, 16'h0101, "d03");
    check("d03.const", {16'h0, S}, 32'h81FF);
    step(1'b1, 16'hFFFF, 16'hFFFF, "d04");
    check("d04.const", {15'h0, Co, S}, 32'h1FFFF);
    step(1'b1, 16'h0200, 16'h0200, "d05");
    check("d05.const", {15'h0, Co, S}, 32'h00400);
    step(1'b1, 16'h5555, 16'hAAAA, "d06");
    check("d06.const", {15'h0, Co, S}, 32'h0FFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h1234, 16'h4321, "hold");
    check("hold.const", {15'h0, Co, S}, 32'h0FFFF);

    // Reset mid-stream must clear outputs without a clock edge
    step(1'b1, 16'hFFFF, 16'hFFFF, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    X = 16'hFFFF;
    Y = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async.S",   {16'h0, S},  32'h0);
    check("rst_async.Co",  {31'h0, Co}, 32'h0);
    check("rst_async.vld", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held.S", {16'h0, S}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_s  = '0;
    exp_co = 1'b0;

    // Randomised vectors; also accumulate approximation error vs. exact sum
    err_sum = 0.0;
    for (int i = 0; i < 10000; i++) begin
      xr = $urandom_range(0, 16'hFFFF);
      yr = $urandom_range(0, 16'hFFFF);
      if (($urandom % 16) == 0) begin
        step(1'b0, xr[N-1:0], yr[N-1:0], "rnd_idle");
      end else begin
        step(1'b1, xr[N-1:0], yr[N-1:0], "rnd");
        r     = ref_add(xr, yr);
        exact = xr + yr;
        err_sum += (int'(r) > int'(exact)) ? real'(int'(r) - int'(exact))
                                           : real'(int'(exact) - int'(r));
      end
    end
    $display("mean absolute error over random vectors: %0.2f", err_sum / 10000.0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
